// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use hazard detection and bubble insertion.
// Optional bubble performance counter is enabled by defining ID_EX_PERF_EN.

module id_ex_fwd #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic [REGW-1:0]  i_rs,
  input  logic [WIDTH-1:0] i_rf_data,
  input  logic [REGW-1:0]  i_mem_rd,
  input  logic             i_mem_we,
  input  logic [WIDTH-1:0] i_mem_result,
  input  logic [REGW-1:0]  i_wb_rd,
  input  logic             i_wb_we,
  input  logic [WIDTH-1:0] i_wb_result,
  output logic [WIDTH-1:0] o_data
);
  // A nonzero i_rs that matches a destination implies that destination is nonzero.
  always_comb begin
    o_data = i_rf_data;
    if (i_rs == '0)                           o_data = '0;
    else if (i_mem_we && (i_mem_rd == i_rs))  o_data = i_mem_result;
    else if (i_wb_we && (i_wb_rd == i_rs))    o_data = i_wb_result;
  end
endmodule

module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_pc,
  input  logic [WIDTH-1:0] id_rs1_data,
  input  logic [WIDTH-1:0] id_rs2_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [REGW-1:0]  id_rs1,
  input  logic [REGW-1:0]  id_rs2,
  input  logic [REGW-1:0]  id_rd,
  input  logic [3:0]       id_alu_ctrl,
  input  logic             id_alu_src_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic [1:0]       id_result_src,
  input  logic [REGW-1:0]  mem_rd,
  input  logic             mem_reg_write,
  input  logic [WIDTH-1:0] mem_result,
  input  logic [REGW-1:0]  wb_rd,
  input  logic             wb_reg_write,
  input  logic [WIDTH-1:0] wb_result,
  output logic             load_use_stall,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_f,
  output logic [WIDTH-1:0] ex_store_data,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_pc,
  output logic [REGW-1:0]  ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic [1:0]       ex_result_src,
  output logic [31:0]      bubble_count
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs1_data;
    logic [WIDTH-1:0] rs2_data;
    logic [WIDTH-1:0] imm;
    logic [REGW-1:0]  rs1;
    logic [REGW-1:0]  rs2;
    logic [REGW-1:0]  rd;
    logic [3:0]       alu_ctrl;
    logic             alu_src_imm;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [1:0]       result_src;
  } ex_t;

  ex_t  r_ex;
  ex_t  w_cap;
  logic w_load_use;

  // Invalid ID slots enter EX with all control cleared so they cannot write state.
  always_comb begin
    w_cap             = '0;
    w_cap.valid       = id_valid;
    w_cap.pc          = id_pc;
    w_cap.rs1_data    = id_rs1_data;
    w_cap.rs2_data    = id_rs2_data;
    w_cap.imm         = id_imm;
    w_cap.rs1         = id_rs1;
    w_cap.rs2         = id_rs2;
    w_cap.rd          = id_rd;
    if (id_valid) begin
      w_cap.alu_ctrl    = id_alu_ctrl;
      w_cap.alu_src_imm = id_alu_src_imm;
      w_cap.reg_write   = id_reg_write;
      w_cap.mem_read    = id_mem_read;
      w_cap.mem_write   = id_mem_write;
      w_cap.result_src  = id_result_src;
    end
  end

  always_comb begin
    w_load_use = 1'b0;
    if (!flush && r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) && id_valid)
      w_load_use = (r_ex.rd == id_rs1) ||
                   ((r_ex.rd == id_rs2) && (!id_alu_src_imm || id_mem_write));
  end
  assign load_use_stall = w_load_use;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_ex <= '0;
    else if (flush)      r_ex <= '0;
    else if (stall)      r_ex <= r_ex;
    else if (w_load_use) r_ex <= '0;
    else                 r_ex <= w_cap;
  end

  logic [1:0][REGW-1:0]  w_rs;
  logic [1:0][WIDTH-1:0] w_rf;
  logic [1:0][WIDTH-1:0] w_fwd;

  assign w_rs = {r_ex.rs2, r_ex.rs1};
  assign w_rf = {r_ex.rs2_data, r_ex.rs1_data};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    id_ex_fwd #(.WIDTH(WIDTH), .REGW(REGW)) u_fwd (
      .i_rs        (w_rs[g]),
      .i_rf_data   (w_rf[g]),
      .i_mem_rd    (mem_rd),
      .i_mem_we    (mem_reg_write),
      .i_mem_result(mem_result),
      .i_wb_rd     (wb_rd),
      .i_wb_we     (wb_reg_write),
      .i_wb_result (wb_result),
      .o_data      (w_fwd[g])
    );
  end

  assign alu_a         = w_fwd[0];
  assign alu_b         = r_ex.alu_src_imm ? r_ex.imm : w_fwd[1];
  assign alu_f         = r_ex.alu_ctrl;
  assign ex_store_data = w_fwd[1];
  assign ex_valid      = r_ex.valid;
  assign ex_pc         = r_ex.pc;
  assign ex_rd         = r_ex.rd;
  assign ex_reg_write  = r_ex.reg_write;
  assign ex_mem_read   = r_ex.mem_read;
  assign ex_mem_write  = r_ex.mem_write;
  assign ex_result_src = r_ex.result_src;

`ifdef ID_EX_PERF_EN
  // Counts inserted bubbles only; a held stall is not a new bubble.
  logic        w_bubble;
  logic [31:0] r_bubble_count;
  assign w_bubble = flush || (!stall && w_load_use);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               r_bubble_count <= '0;
    else if (w_bubble && (r_bubble_count != '1)) r_bubble_count <= r_bubble_count + 32'd1;
  end
  assign bubble_count = r_bubble_count;
`else
  assign bubble_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding priority, load-use, immediate, stall/flush, async reset.
module tb_id_ex_stage;
`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src_imm, id_reg_write, id_mem_read, id_mem_write;
  logic [1:0]  id_result_src;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        load_use_stall;
  logic [31:0] alu_a, alu_b, ex_store_data, ex_pc, bubble_count;
  logic [3:0]  alu_f;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_result_src;

  int errs = 0;
  int checks = 0;

  id_ex_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src_imm(id_alu_src_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_result_src(id_result_src),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_result_src(ex_result_src), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, rs1d, rs2d, imm,
                        input logic [4:0] rs1, rs2, rd, input logic [3:0] ctrl,
                        input logic src, rw, mr, mw, input logic [1:0] rsrc);
    id_valid = v; id_pc = pc; id_rs1_data = rs1d; id_rs2_data = rs2d; id_imm = imm;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_alu_ctrl = ctrl;
    id_alu_src_imm = src; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_result_src = rsrc;
  endtask

  task automatic set_fwd(input logic mwe, input logic [4:0] mrd, input logic [31:0] mres,
                         input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
    mem_reg_write = mwe; mem_rd = mrd; mem_result = mres;
    wb_reg_write = wwe; wb_rd = wrd; wb_result = wres;
  endtask

  initial begin
    // Reset held with random inputs
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_id($urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
             5'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom, 2'($urandom));
      set_fwd($urandom, 5'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
      tick();
    end
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_alu_f", 32'(alu_f), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_lus", 32'(load_use_stall), 32'd0);
    chk("rst_bubbles", bubble_count, 32'd0);

    // First capture after reset release
    rst_n = 1'b1;
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h100, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 4'd2, 0, 1, 0, 0, 2'd0);
    tick();
    chk("cap_alu_a", alu_a, 32'd5);
    chk("cap_alu_b", alu_b, 32'd7);
    chk("cap_alu_f", 32'(alu_f), 32'd2);
    chk("cap_valid", 32'(ex_valid), 32'd1);
    chk("cap_rd", 32'(ex_rd), 32'd3);
    chk("cap_pc", ex_pc, 32'h100);

    // Forwarding priority on rs1=3
    set_id(1, 32'h104, 32'h99, 32'h0, 32'h0, 5'd3, 5'd0, 5'd4, 4'd0, 0, 1, 0, 0, 2'd0);
    tick();
    set_fwd(1, 5'd3, 32'h11, 1, 5'd3, 32'h22);
    #1 chk("fwd_mem", alu_a, 32'h11);
    mem_reg_write = 1'b0;
    #1 chk("fwd_wb", alu_a, 32'h22);
    wb_reg_write = 1'b0;
    #1 chk("fwd_rf", alu_a, 32'h99);
    set_id(1, 32'h108, 32'h55, 32'h0, 32'h0, 5'd0, 5'd0, 5'd4, 4'd0, 0, 1, 0, 0, 2'd0);
    set_fwd(1, 5'd0, 32'h11, 1, 5'd0, 32'h22);
    tick();
    chk("fwd_x0", alu_a, 32'd0);

    // Load-use: lw x5, then add using x5
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h10C, 32'h100, 32'h0, 32'd8, 5'd2, 5'd0, 5'd5, 4'd2, 1, 1, 1, 0, 2'd1);
    tick();
    chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
    set_id(1, 32'h110, 32'hDEAD, 32'd3, 32'h0, 5'd5, 5'd6, 5'd7, 4'd2, 0, 1, 0, 0, 2'd0);
    #1 chk("lu_stall", 32'(load_use_stall), 32'd1);
    tick();
    chk("lu_bub_rw", 32'(ex_reg_write), 32'd0);
    chk("lu_bub_valid", 32'(ex_valid), 32'd0);
    chk("lu_cleared", 32'(load_use_stall), 32'd0);
    chk("lu_count", bubble_count, PERF ? 32'd1 : 32'd0);
    set_fwd(0, 0, 0, 1, 5'd5, 32'h1234);
    tick();
    chk("lu_fwd_a", alu_a, 32'h1234);
    chk("lu_b", alu_b, 32'd3);
    chk("lu_rd", 32'(ex_rd), 32'd7);

    // Immediate operand ignores rs2 hazard; store does not; flush masks it
    set_fwd(0, 0, 0, 0, 0, 0);
    set_id(1, 32'h114, 32'h0, 32'h0, 32'd0, 5'd2, 5'd0, 5'd6, 4'd2, 1, 1, 1, 0, 2'd1);
    tick();
    set_id(1, 32'h118, 32'h10, 32'h0, 32'hFFFF_FFFC, 5'd1, 5'd6, 5'd8, 4'd2, 1, 1, 0, 0, 2'd0);
    #1 chk("imm_no_stall", 32'(load_use_stall), 32'd0);
    id_mem_write = 1'b1;
    #1 chk("st_stall", 32'(load_use_stall), 32'd1);
    flush = 1'b1;
    #1 chk("flush_mask", 32'(load_use_stall), 32'd0);
    flush = 1'b0; id_mem_write = 1'b0;
    tick();
    chk("imm_alu_b", alu_b, 32'hFFFF_FFFC);
    chk("imm_alu_a", alu_a, 32'h10);

    // Stall holds for three cycles, then flush wins over stall
    stall = 1'b1;
    set_id(1, 32'h11C, 32'h77, 32'h66, 32'h0, 5'd1, 5'd2, 5'd9, 4'd7, 0, 1, 0, 0, 2'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_a", alu_a, 32'h10);
      chk("stall_b", alu_b, 32'hFFFF_FFFC);
      chk("stall_rd", 32'(ex_rd), 32'd8);
    end
    flush = 1'b1;
    tick();
    chk("sf_valid", 32'(ex_valid), 32'd0);
    chk("sf_alu_f", 32'(alu_f), 32'd0);
    chk("sf_count", bubble_count, PERF ? 32'd2 : 32'd0);

    // Asynchronous reset between edges
    stall = 1'b0; flush = 1'b0;
    set_id(1, 32'h120, 32'h42, 32'h0, 32'h0, 5'd1, 5'd0, 5'd3, 4'd3, 0, 1, 0, 0, 2'd0);
    tick();
    chk("pre_ar_valid", 32'(ex_valid), 32'd1);
    chk("pre_ar_a", alu_a, 32'h42);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(ex_valid), 32'd0);
    chk("ar_alu_a", alu_a, 32'd0);
    chk("ar_alu_f", 32'(alu_f), 32'd0);
    chk("ar_count", bubble_count, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
